multiscale_window_sum: RTL and testbench

//  Parametrised cascade of decimating sliding-window sums for feature streams (e.g. line length).

---
 rtl/multiscale_window_sum.sv | 171 +++++++++++++++++
 tb/tb_multiscale_window_sum.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiscale_window_sum.sv
// Cascade of decimating sliding-window sums.
// Level 0 bins SAMPLES_PER_BUCKET samples into a bucket. Each of the three ring
// levels keeps a running sum over its last Dk entries. Level k+1 receives the
// post-update level-k sum once every Dk level-k pushes.
//
// Handshake: in_valid qualifies din on a rising edge. There is no ready signal;
// the block accepts every sample and never stalls. Each lk_valid is a one-cycle
// pulse that marks the cycle in which lk_sum (and l3_mean for level 3) changed.
module multiscale_window_sum #(
  parameter int IN_W               = 25,
  parameter int ACC_W              = 48,
  parameter int SAMPLES_PER_BUCKET = 250,
  parameter int D1                 = 5,
  parameter int D2                 = 6,
  parameter int D3                 = 8,
  parameter int EMIT_PARTIAL       = 0,
  parameter int SHIFT              = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  din,
  output logic signed [ACC_W-1:0] l1_sum,
  output logic                    l1_valid,
  output logic signed [ACC_W-1:0] l2_sum,
  output logic                    l2_valid,
  output logic signed [ACC_W-1:0] l3_sum,
  output logic                    l3_valid,
  output logic signed [ACC_W-1:0] l3_mean,
  output logic [2:0]              levels_full
);

  localparam int CW = (SAMPLES_PER_BUCKET > 1) ? $clog2(SAMPLES_PER_BUCKET) : 1;

  // clear behaves exactly like rst and also drops the sample on that edge
  logic                    srst;
  logic signed [ACC_W-1:0] din_ext;

  assign srst    = rst | clear;
  assign din_ext = {{(ACC_W-IN_W){din[IN_W-1]}}, din};

  // Level 0: bucket accumulator
  logic [CW-1:0]           cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] bucket;
  logic                    bucket_push;

  // Accumulate accepted samples; the last sample of a bucket emits acc+din
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt         <= '0;
      acc         <= '0;
      bucket      <= '0;
      bucket_push <= 1'b0;
    end else begin
      bucket_push <= 1'b0;
      if (in_valid) begin
        if (cnt == CW'(SAMPLES_PER_BUCKET - 1)) begin
          bucket      <= acc + din_ext;
          acc         <= '0;
          cnt         <= '0;
          bucket_push <= 1'b1;
        end else begin
          acc <= acc + din_ext;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Per-level interconnect: push strobe and value into each level, the
  // post-update sum of each level, and the ring-wrap strobe that feeds the next
  logic [2:0]              lvl_push;
  logic [1:0]              lvl_wrap;
  logic signed [ACC_W-1:0] lvl_in   [3];
  logic signed [ACC_W-1:0] lvl_next [3];
  logic signed [ACC_W-1:0] lvl_sum  [3];
  logic [2:0]              lvl_valid;
  logic [2:0]              lvl_full;

  for (genvar k = 0; k < 3; k++) begin : g_lvl
    localparam int D  = (k == 0) ? D1 : (k == 1) ? D2 : D3;
    localparam int PW = (D > 1) ? $clog2(D) : 1;

    logic signed [ACC_W-1:0] ring [D];
    logic [PW-1:0]           wr;
    logic signed [ACC_W-1:0] sum_r;
    logic                    full_r;
    logic                    valid_r;
    logic                    at_end;

    if (k == 0) begin : g_src_bucket
      assign lvl_push[k] = bucket_push;
      assign lvl_in[k]   = bucket;
    end else begin : g_src_level
      logic                    pend;
      logic signed [ACC_W-1:0] pend_val;

      // Register the previous level's post-update sum when its ring wraps
      always_ff @(posedge clk) begin
        if (srst) begin
          pend     <= 1'b0;
          pend_val <= '0;
        end else begin
          pend     <= lvl_push[k-1] & lvl_wrap[k-1];
          pend_val <= lvl_next[k-1];
        end
      end

      assign lvl_push[k] = pend;
      assign lvl_in[k]   = pend_val;
    end

    // Slot being overwritten is the oldest entry; a zeroed ring makes warm-up add only
    assign at_end      = (wr == PW'(D - 1));
    assign lvl_next[k] = sum_r + lvl_in[k] - ring[wr];

    if (k < 2) begin : g_wrap
      assign lvl_wrap[k] = lvl_push[k] & at_end;
    end

    // Ring write, running-sum update, fill flag and valid pulse
    always_ff @(posedge clk) begin
      if (srst) begin
        wr      <= '0;
        sum_r   <= '0;
        full_r  <= 1'b0;
        valid_r <= 1'b0;
        for (int i = 0; i < D; i++) ring[i] <= '0;
      end else begin
        valid_r <= lvl_push[k] & ((EMIT_PARTIAL != 0) | full_r | at_end);
        if (lvl_push[k]) begin
          ring[wr] <= lvl_in[k];
          sum_r    <= lvl_next[k];
          wr       <= at_end ? '0 : wr + 1'b1;
          if (at_end) full_r <= 1'b1;
        end
      end
    end

    assign lvl_sum[k]   = sum_r;
    assign lvl_valid[k] = valid_r;
    assign lvl_full[k]  = full_r;
  end

  // Round-half-up scaling of the level-3 sum
  logic signed [ACC_W-1:0] mean_next;

  if (SHIFT == 0) begin : g_mean_pass
    assign mean_next = lvl_next[2];
  end else begin : g_mean_round
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (SHIFT - 1);
    assign mean_next = (lvl_next[2] + HALF) >>> SHIFT;
  end

  // l3_mean is registered on the same edge as l3_sum
  always_ff @(posedge clk) begin
    if (srst) l3_mean <= '0;
    else if (lvl_push[2]) l3_mean <= mean_next;
  end

  assign l1_sum      = lvl_sum[0];
  assign l2_sum      = lvl_sum[1];
  assign l3_sum      = lvl_sum[2];
  assign l1_valid    = lvl_valid[0];
  assign l2_valid    = lvl_valid[1];
  assign l3_valid    = lvl_valid[2];
  assign levels_full = lvl_full;

endmodule

// File: tb/tb_multiscale_window_sum.sv
// Bench for multiscale_window_sum: two instances (EMIT_PARTIAL 0 and 1) share
// one input stream. A queue-based model of buckets and window entries predicts
// every output each cycle; directed literal checks pin both DUT and model.
module tb_multiscale_window_sum;
  localparam int IN_W  = 25;
  localparam int ACC_W = 48;
  localparam int SPB   = 4;
  localparam int DD1   = 2;
  localparam int DD2   = 2;
  localparam int DD3   = 2;
  localparam int SHF   = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic signed [IN_W-1:0] din = '0;

  always #5 clk = ~clk;

  // DUT outputs, index 0 = EMIT_PARTIAL 0, index 1 = EMIT_PARTIAL 1
  logic signed [ACC_W-1:0] sm [2][3];
  logic signed [ACC_W-1:0] mn [2];
  logic [2:0]              vl [2];
  logic [2:0]              fl [2];

  multiscale_window_sum #(.IN_W(IN_W), .ACC_W(ACC_W), .SAMPLES_PER_BUCKET(SPB),
    .D1(DD1), .D2(DD2), .D3(DD3), .EMIT_PARTIAL(0), .SHIFT(SHF)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .din(din),
    .l1_sum(sm[0][0]), .l1_valid(vl[0][0]), .l2_sum(sm[0][1]), .l2_valid(vl[0][1]),
    .l3_sum(sm[0][2]), .l3_valid(vl[0][2]), .l3_mean(mn[0]), .levels_full(fl[0]));

  multiscale_window_sum #(.IN_W(IN_W), .ACC_W(ACC_W), .SAMPLES_PER_BUCKET(SPB),
    .D1(DD1), .D2(DD2), .D3(DD3), .EMIT_PARTIAL(1), .SHIFT(SHF)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .din(din),
    .l1_sum(sm[1][0]), .l1_valid(vl[1][0]), .l2_sum(sm[1][1]), .l2_valid(vl[1][1]),
    .l3_sum(sm[1][2]), .l3_valid(vl[1][2]), .l3_mean(mn[1]), .levels_full(fl[1]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_acc = 0;
  int     m_cnt = 0;
  longint bk[$];
  longint l2e[$];
  longint l3e[$];
  longint dl_sum  [3][3];
  bit     dl_upd  [3][3];
  bit     dl_full [3][3];
  longint e_sum [3];
  bit     e_upd [3];
  bit     e_full[3];
  longint e_mean = 0;

  function automatic longint win_sum(input longint q[$], input int d);
    longint s = 0;
    int lo = (q.size() > d) ? q.size() - d : 0;
    for (int i = lo; i < q.size(); i++) s += q[i];
    return s;
  endfunction

  function automatic longint round_mean(input longint s);
    longint den = longint'(1) << SHF;
    longint num = s + den / 2;
    longint q = num / den;
    if ((num % den) != 0 && num < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_cnt = 0;
    bk.delete(); l2e.delete(); l3e.delete();
    e_mean = 0;
    for (int k = 0; k < 3; k++) begin
      e_sum[k] = 0; e_upd[k] = 0; e_full[k] = 0;
      for (int j = 0; j < 3; j++) begin
        dl_sum[k][j] = 0; dl_upd[k][j] = 0; dl_full[k][j] = 0;
      end
    end
  endtask

  // Level k results appear k+1 edges after the bucket-completing sample
  always @(posedge clk) begin
    if (rst || clear) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        e_upd[k] = dl_upd[k][0];
        if (dl_upd[k][0]) begin
          e_sum[k]  = dl_sum[k][0];
          e_full[k] = dl_full[k][0];
          if (k == 2) e_mean = round_mean(e_sum[2]);
        end
        for (int j = 0; j < 2; j++) begin
          dl_sum[k][j] = dl_sum[k][j+1]; dl_upd[k][j] = dl_upd[k][j+1];
          dl_full[k][j] = dl_full[k][j+1];
        end
        dl_upd[k][2] = 0;
      end
      if (in_valid) begin
        m_acc += longint'(din);
        m_cnt++;
        if (m_cnt == SPB) begin
          longint s1, s2, s3;
          bk.push_back(m_acc);
          m_acc = 0; m_cnt = 0;
          s1 = win_sum(bk, DD1);
          dl_upd[0][0] = 1; dl_sum[0][0] = s1; dl_full[0][0] = (bk.size() >= DD1);
          if (bk.size() % DD1 == 0) begin
            l2e.push_back(s1);
            s2 = win_sum(l2e, DD2);
            dl_upd[1][1] = 1; dl_sum[1][1] = s2; dl_full[1][1] = (l2e.size() >= DD2);
            if (l2e.size() % DD2 == 0) begin
              l3e.push_back(s2);
              s3 = win_sum(l3e, DD3);
              dl_upd[2][2] = 1; dl_sum[2][2] = s3; dl_full[2][2] = (l3e.size() >= DD3);
            end
          end
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  bit chk_en = 0;
  bit saw_a [3];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("dut%0d_l%0d_sum", i, k+1), sm[i][k], e_sum[k]);
          chk($sformatf("dut%0d_l%0d_valid", i, k+1), vl[i][k],
              (e_upd[k] && (i == 1 || e_full[k])) ? 1 : 0);
        end
        chk($sformatf("dut%0d_levels_full", i), fl[i],
            {29'd0, e_full[2], e_full[1], e_full[0]});
        chk($sformatf("dut%0d_l3_mean", i), mn[i], e_mean);
      end
      for (int k = 0; k < 3; k++) if (vl[0][k]) saw_a[k] = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    din = IN_W'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input int v);
    repeat (n) send(v);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Hold clear (or rst) with a sample presented, which must be dropped
  task automatic do_clear(input int n, input bit use_rst);
    if (use_rst) rst = 1'b1; else clear = 1'b1;
    in_valid = 1'b1;
    din = IN_W'(7);
    repeat (n) tick();
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) saw_a[k] = 0;
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("%s_sum%0d_%0d", tag, i, k+1), sm[i][k], 0);
      end
      chk($sformatf("%s_valid%0d", tag, i), vl[i], 0);
      chk($sformatf("%s_full%0d", tag, i), fl[i], 0);
      chk($sformatf("%s_mean%0d", tag, i), mn[i], 0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) tick();
    rst = 1'b0;
    chk_en = 1;
    chk_zero("reset");

    // din = 1 constant
    send_n(7, 1); idle(3);
    chk("ones_no_l1_valid", saw_a[0], 0);
    chk("ones_warm_l1", sm[0][0], 4);
    send(1); idle(1);
    chk("ones_l1_valid", vl[0][0], 1);
    chk("ones_l1_sum", sm[0][0], 8);
    chk("model_ones_l1", e_sum[0], 8);
    send_n(8, 1); idle(3);
    chk("ones_l2_sum", sm[0][1], 16);
    chk("ones_l2_full", fl[0][1], 1);
    chk("ones_no_l3_valid", saw_a[2], 0);
    send_n(16, 1); idle(4);
    chk("ones_l3_sum", sm[0][2], 32);
    chk("model_ones_l3", e_sum[2], 32);
    chk("ones_l3_mean", mn[0], 1);
    chk("ones_full", fl[0], 7);
    chk("ones_l3_valid_seen", saw_a[2], 1);

    // clear held with a sample present
    do_clear(2, 0);
    chk_zero("clear");

    // din = -3 constant: sign path
    send_n(32, -3); idle(4);
    chk("neg_l1_sum", sm[0][0], -24);
    chk("neg_l2_sum", sm[0][1], -48);
    chk("neg_l3_sum", sm[0][2], -96);
    chk("neg_l3_mean", mn[0], -3);
    chk("model_neg_mean", e_mean, -3);

    // window slide: oldest bucket drops out
    do_clear(1, 0);
    send_n(4, 1); send_n(4, 2); idle(2);
    chk("slide_l1_b2", sm[0][0], 12);
    send_n(4, 3); idle(2);
    chk("slide_l1_b3", sm[0][0], 20);
    chk("model_slide", e_sum[0], 20);

    // partial emission on dut_b only
    do_clear(1, 0);
    send_n(4, 1); idle(1);
    chk("part_b_l1_valid", vl[1][0], 1);
    chk("part_b_l1_sum", sm[1][0], 4);
    chk("part_a_l1_valid", vl[0][0], 0);
    send_n(4, 1); idle(1); idle(1);
    chk("part_b_l2_valid", vl[1][1], 1);
    chk("part_b_l2_sum", sm[1][1], 8);

    // mid-bucket clear discards the partial bucket
    do_clear(1, 0);
    send_n(6, 1);
    do_clear(1, 0);
    send_n(7, 1); idle(3);
    chk("reclr_no_valid", saw_a[0], 0);
    send(1); idle(1);
    chk("reclr_l1_valid", vl[0][0], 1);
    chk("reclr_l1_sum", sm[0][0], 8);

    // rst mid-bucket with a sample present
    send_n(2, 5);
    do_clear(1, 1);
    chk_zero("rst_mid");

    // irregular gaps and mixed-sign samples, checked by the scoreboard
    for (int i = 0; i < 48; i++) begin
      send($urandom_range(0, 20) - 10);
      idle($urandom_range(0, 2));
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
